// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver in the system clock domain: sync/filter, frame FSM, E0/F0 decode, event FIFO.
// Optional frame watchdog built only when PS2_TIMEOUT_EN is defined.
module ps2_kbd_ctrl #(
    parameter int FILT_LEN    = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       Clk,
    input  logic       Resetn,
    input  logic       KeyClk,
    input  logic       KeyData,
    input  logic       EvReady,
    input  logic       ErrClr,
    output logic       EvValid,
    output logic [7:0] EvCode,
    output logic       EvBreak,
    output logic       EvExt,
    output logic       FrameErr,
    output logic       Overflow,
    output logic [1:0] DbgState
);

    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PAR = 2'd2, S_STOP = 2'd3} state_t;

    // Input path: bus idles high, so synchronisers and filter preset to 1.
    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           strobe;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
        end else begin
            clk_s1_q <= KeyClk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= KeyData;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILT_LEN - 1)) filt_d = clk_s2_q;
            else                              fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign strobe = filt_q && !filt_d;

    // Frame FSM
    state_t     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] sh_q, sh_d;
    logic       byte_ok_q, byte_ok_d;
    logic       err_q, err_d;
    logic       timeout;

`ifdef PS2_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (state_q == S_IDLE || strobe)   wd_d = '0;
        else if (wd_q != WDW'(TIMEOUT_CYC)) wd_d = wd_q + 1'b1;
    end

    assign timeout = !strobe && (state_q != S_IDLE) && (wd_q == WDW'(TIMEOUT_CYC - 1));

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) wd_q <= '0;
        else         wd_q <= wd_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        sh_d      = sh_q;
        byte_ok_d = 1'b0;
        err_d     = 1'b0;
        if (strobe) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    sh_d[bitcnt_q] = dat_s2_q;
                    if (bitcnt_q == 3'd7) state_d = S_PAR;
                    else                  bitcnt_d = bitcnt_q + 1'b1;
                end
                S_PAR: begin
                    if (^{sh_q, dat_s2_q}) state_d = S_STOP;
                    else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (dat_s2_q) byte_ok_d = 1'b1;
                    else          err_d     = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            sh_q      <= '0;
            byte_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            sh_q      <= sh_d;
            byte_ok_q <= byte_ok_d;
            err_q     <= err_d;
        end
    end

    // Prefix decode: E0/F0 only arm flags; any other byte becomes an event.
    logic ext_q, ext_d, brk_q, brk_d;
    logic is_e0, is_f0, push;

    assign is_e0 = (sh_q == 8'hE0);
    assign is_f0 = (sh_q == 8'hF0);
    assign push  = byte_ok_q && !is_e0 && !is_f0;

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        if (err_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok_q) begin
            if (is_e0)      ext_d = 1'b1;
            else if (is_f0) brk_d = 1'b1;
            else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // Event FIFO (show-ahead); a pop in the same cycle frees room for a push into a full FIFO.
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          full, pop, wr_en, ovf_set;

    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign pop     = EvValid && EvReady;
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_comb begin
        unique case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (ovf_set)     ovf_d = 1'b1;
        else if (ErrClr) ovf_d = 1'b0;
        else             ovf_d = ovf_q;
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= {ext_q, brk_q, sh_q};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end

    assign EvValid                  = (cnt_q != '0);
    assign {EvExt, EvBreak, EvCode} = mem_q[rd_ptr_q];
    assign FrameErr                 = err_q;
    assign Overflow                 = ovf_q;
    assign DbgState                 = state_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: event-level model (queue + prefix flags) checked every cycle.
module tb_ps2_kbd_ctrl;
    localparam int FILT_LEN    = 4;
    localparam int DEPTH       = 4;
    localparam int TIMEOUT_CYC = 5000;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       key_clk = 1'b1, key_data = 1'b1, ev_ready = 1'b0, err_clr = 1'b0;
    logic       ev_valid, ev_break, ev_ext, frame_err, overflow;
    logic [7:0] ev_code;
    logic [1:0] dbg_state;

    ps2_kbd_ctrl #(.FILT_LEN(FILT_LEN), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .Clk(clk), .Resetn(rst_n), .KeyClk(key_clk), .KeyData(key_data),
        .EvReady(ev_ready), .ErrClr(err_clr), .EvValid(ev_valid), .EvCode(ev_code),
        .EvBreak(ev_break), .EvExt(ev_ext), .FrameErr(frame_err), .Overflow(overflow),
        .DbgState(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: expected FIFO contents {ext,brk,code}, prefix flags, sticky overflow.
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    bit         m_ovf = 0, m_ext = 0, m_brk = 0;
    bit         model_on = 0, ignore_ferr = 0;
    int         sch_cyc[$];
    int         sch_kind[$];
    logic [7:0] sch_byte[$];
    int         lat = 7;
    int         last_fall_k = 0;
    int         first_valid_cyc = -1;
    int         ferr_cnt = 0;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (!model_on && ev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    end

    // Compare process
    bit         c_ferr, c_byte, c_pop, c_set, c_push;
    logic [7:0] c_b;
    always @(negedge clk) begin
        if (model_on) begin
            c_ferr = 0; c_byte = 0; c_b = 8'h00; c_set = 0; c_push = 0;
            if (sch_cyc.size() > 0 && sch_cyc[0] == cyc) begin
                if (sch_kind[0] == 1) c_ferr = 1;
                else begin c_byte = 1; c_b = sch_byte[0]; end
                void'(sch_cyc.pop_front());
                void'(sch_kind.pop_front());
                void'(sch_byte.pop_front());
            end
            check("ev_valid", ev_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("ev_head", {ev_ext, ev_break, ev_code}, exp_q[0]);
            check("overflow", overflow, m_ovf);
            if (!ignore_ferr) check("frame_err", frame_err, c_ferr);
            c_pop = ev_ready && (exp_q.size() != 0);
            if (c_ferr) begin
                m_ext = 0; m_brk = 0;
            end else if (c_byte) begin
                if (c_b == 8'hE0)      m_ext = 1;
                else if (c_b == 8'hF0) m_brk = 1;
                else begin
                    if (exp_q.size() == DEPTH && !c_pop) c_set = 1;
                    else                                 c_push = 1;
                end
            end
            if (c_pop) got_q.push_back(exp_q.pop_front());
            if (c_push) begin
                exp_q.push_back({m_ext, m_brk, c_b});
                m_ext = 0; m_brk = 0;
            end else if (c_set) begin
                m_ext = 0; m_brk = 0;
            end
            if (c_set)        m_ovf = 1;
            else if (err_clr) m_ovf = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // skind: -1 nothing, 0 byte completes on this falling edge, 1 frame error on this edge
    task automatic send_bit(input logic b, input bit glitch, input bit ready_pulse,
                            input int skind, input logic [7:0] sbyte);
        key_data = b;
        step(4);
        if (glitch) begin
            key_clk = 1'b0;
            step(FILT_LEN - 1);
            key_clk = 1'b1;
        end
        step(10);
        key_clk = 1'b0;
        last_fall_k = cyc;
        if (skind >= 0 && model_on) begin
            sch_cyc.push_back(cyc + lat - 1);
            sch_kind.push_back(skind);
            sch_byte.push_back(sbyte);
        end
        if (ready_pulse) begin
            step(lat - 1);
            ev_ready = 1'b1;
            step(1);
            ev_ready = 1'b0;
            step(20 - lat);
        end else step(20);
        key_clk = 1'b1;
        step(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch_bit, input bit ready_pulse);
        logic p;
        p = (~^b) ^ bad_par;
        send_bit(1'b0, glitch_bit == 0, 1'b0, -1, b);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i + 1, 1'b0, -1, b);
        send_bit(p, 1'b0, 1'b0, bad_par ? 1 : -1, b);
        send_bit(~bad_stop, 1'b0, ready_pulse, bad_par ? -1 : (bad_stop ? 1 : 0), b);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        ev_ready = 1'b1;
        while (exp_q.size() != 0 && n < max_cyc) begin step(1); n++; end
        check("drain_done", n < max_cyc, 1'b1);
        step(2);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        // Reset
        step(3);
        check("rst_valid", ev_valid, 1'b0);
        check("rst_code", ev_code, 8'h00);
        check("rst_brk_ext", {ev_break, ev_ext}, 2'b00);
        check("rst_ferr_ovf", {frame_err, overflow}, 2'b00);
        check("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;
        step(5);
        check("idle_valid", ev_valid, 1'b0);

        // Latency calibration from the stop falling edge to EvValid
        send_frame(8'h1C, 0, 0, -1, 0);
        check("cal_seen", first_valid_cyc >= 0, 1'b1);
        lat = first_valid_cyc - last_fall_k;
        check("cal_latency_window", (lat >= 4 && lat <= 12), 1'b1);
        if (lat < 4 || lat > 12) lat = 7;
        check("cal_event", {ev_valid, ev_ext, ev_break, ev_code}, {3'b100, 8'h1C});
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        step(2);
        check("cal_popped", ev_valid, 1'b0);
        model_on = 1;
        step(2);

        // 1: plain make code
        got_q.delete();
        ev_ready = 1'b1;
        send_frame(8'h1C, 0, 0, -1, 0);
        step(10);
        check("t1_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t1_event", got_q[0], 10'h01C);

        // 2: break prefix, then extended break
        got_q.delete();
        send_frame(8'hF0, 0, 0, -1, 0);
        send_frame(8'h1C, 0, 0, -1, 0);
        send_frame(8'hE0, 0, 0, -1, 0);
        send_frame(8'hF0, 0, 0, -1, 0);
        send_frame(8'h75, 0, 0, -1, 0);
        step(10);
        check("t2_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t2_break", got_q[0], 10'h11C);
            check("t2_ext_break", got_q[1], 10'h375);
        end

        // 3: parity error, then prefix wiped by a stop error
        got_q.delete();
        ferr_cnt = 0;
        send_frame(8'h1C, 1, 0, -1, 0);
        send_frame(8'hF0, 0, 0, -1, 0);
        send_frame(8'h22, 0, 1, -1, 0);
        send_frame(8'h1C, 0, 0, -1, 0);
        step(10);
        check("t3_ferr_pulses", ferr_cnt, 2);
        check("t3_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t3_event", got_q[0], 10'h01C);

        // 4: overflow with consumer stalled
        got_q.delete();
        ev_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, -1, 0);
        step(5);
        check("t4_overflow", overflow, 1'b1);
        check("t4_head", {ev_valid, ev_code}, {1'b1, 8'h01});
        drain(20);
        ev_ready = 1'b0;
        check("t4_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("t4_order", got_q[i], 10'(i + 1));
        check("t4_ovf_held", overflow, 1'b1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        step(2);
        check("t4_ovf_clr", overflow, 1'b0);

        // 5: clock glitch mid-frame, then push and pop coinciding on a full FIFO
        got_q.delete();
        ev_ready = 1'b1;
        send_frame(8'h3A, 0, 0, 4, 0);
        step(10);
        check("t5_glitch_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t5_glitch_event", got_q[0], 10'h03A);
        got_q.delete();
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 0, 0, -1, 0);
        send_frame(8'h14, 0, 0, -1, 1);
        step(5);
        check("t5_no_ovf", overflow, 1'b0);
        drain(20);
        ev_ready = 1'b0;
        check("t5_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) check("t5_order", got_q[i], 10'h010 + 10'(i));

        // 6: KeyClk stops after 5 bits
        got_q.delete();
        ev_ready = 1'b1;
        ferr_cnt = 0;
        ignore_ferr = 1;
        send_bit(1'b0, 1'b0, 1'b0, -1, 8'h00);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0, -1, 8'h00);
        step(TIMEOUT_CYC + 10);
`ifdef PS2_TIMEOUT_EN
        check("t6_timeout_pulse", ferr_cnt, 1);
        check("t6_state_idle", dbg_state, 2'd0);
        m_ext = 0;
        m_brk = 0;
        ignore_ferr = 0;
        send_frame(8'h1C, 0, 0, -1, 0);
        step(10);
        check("t6_next_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t6_next_event", got_q[0], 10'h01C);
`else
        check("t6_no_ferr", ferr_cnt, 0);
        check("t6_state_data", dbg_state, 2'd1);
`endif
        step(5);
        check("end_empty", ev_valid, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
